ps2_key_state_tracker: RTL and testbench

Converts the received PS/2 scan-code byte stream into a live pressed-key bitmap (the key-state storage that the note, audio and VGA logic consume), plus a "no key pressed" flag and one-cycle key events. It sits between the PS/2 byte receiver and the note/voice logic. It is a parametrised generalisation: key count, scan-code map and extended-code keys are all parameters. It handles make/break, E0-prefixed keys, prefix timeout recovery and bulk release.

---
 rtl/ps2_key_state_tracker.sv | 153 +++++++++++++++
 tb/tb_ps2_key_state_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_state_tracker.sv
// PS/2 scan-code stream to pressed-key bitmap with per-key make/break events.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of a key already held.
module ps2_key_state_tracker #(
  parameter int                    NUM_KEYS       = 8,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h42, 8'h3B, 8'h33, 8'h34,
                                                     8'h2B, 8'h23, 8'h1B, 8'h1C},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
  parameter int                    TIMEOUT_CYCLES = 50000,
  localparam int                   KW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int                   CW             = $clog2(NUM_KEYS + 1)
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                clear_all,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                no_press,
  output logic [CW-1:0]       active_count,
  output logic                event_valid,
  output logic [KW-1:0]       event_key,
  output logic                event_make
);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t              r_state;
  logic [31:0]         r_tmr;

  state_t              w_state_nxt;
  logic                w_cand;
  logic                w_ext;
  logic                w_break;
  logic                w_hit;
  logic [KW-1:0]       w_idx;
  logic                w_do;
  logic                w_evt;
  logic [NUM_KEYS-1:0] w_next;
  logic [CW-1:0]       w_cnt;
  logic                w_tmo;

  assign w_tmo = (r_state != S_IDLE) && (r_tmr == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_cand      = 1'b0;
    w_ext       = 1'b0;
    w_break     = 1'b0;
    w_state_nxt = r_state;
    if (clear_all) begin
      w_state_nxt = S_IDLE;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      w_state_nxt = S_E0;
          else if (rx_data == 8'hF0) w_state_nxt = S_F0;
          else                       w_cand      = 1'b1;
        end
        S_E0: begin
          if (rx_data == 8'hF0) begin
            w_state_nxt = S_E0F0;
          end else begin
            w_cand      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          w_cand      = 1'b1;
          w_break     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_cand      = 1'b1;
          w_ext       = 1'b1;
          w_break     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      endcase
    end else if (w_tmo) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if ((KEY_CODES[8*i +: 8] == rx_data) && (KEY_EXT[i] == w_ext)) begin
        w_hit = 1'b1;
        w_idx = KW'(i);
      end
    end
  end

  assign w_do = rx_valid && !clear_all && w_cand && w_hit;

  always_comb begin
    w_next = key_state;
    w_evt  = 1'b0;
    if (clear_all) begin
      w_next = '0;
    end else if (w_do) begin
      if (w_break) begin
        if (key_state[w_idx]) begin
          w_next[w_idx] = 1'b0;
          w_evt         = 1'b1;
        end
      end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
        w_evt = !key_state[w_idx];
`else
        w_evt = 1'b1;
`endif
        w_next[w_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_cnt = w_cnt + CW'(w_next[i]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      key_state    <= '0;
      no_press     <= 1'b1;
      active_count <= '0;
      event_valid  <= 1'b0;
      event_key    <= '0;
      event_make   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      key_state    <= w_next;
      no_press     <= (w_next == '0);
      active_count <= w_cnt;
      event_valid  <= w_evt;
      if (w_evt) begin
        event_key  <= w_idx;
        event_make <= !w_break;
      end
      // Prefix watchdog only advances while a prefix is pending and the line is quiet.
      if (clear_all || rx_valid || (r_state == S_IDLE) || w_tmo) r_tmr <= '0;
      else                                                       r_tmr <= r_tmr + 32'd1;
    end
  end

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Scoreboard bench for ps2_key_state_tracker: default instance A and an E0-key instance B.
// Expectations follow PS2_TYPEMATIC_FILTER_EN when it is defined.
module tb_ps2_key_state_tracker;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_a = '0, rx_b = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;

  logic [7:0] ks_a, ks_b;
  logic       np_a, np_b, ev_a, ev_b, mk_a, mk_b;
  logic [3:0] cnt_a, cnt_b;
  logic [2:0] key_a, key_b;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] ks;
    logic       ev;
    logic [2:0] key;
    logic       mk;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  ps2_key_state_tracker u_a (
    .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_a), .rx_valid(vld_a), .clear_all(clr_a),
    .key_state(ks_a), .no_press(np_a), .active_count(cnt_a),
    .event_valid(ev_a), .event_key(key_a), .event_make(mk_a)
  );

  ps2_key_state_tracker #(
    .NUM_KEYS(8),
    .KEY_CODES({8'h74, 8'h3B, 8'h33, 8'h34, 8'h2B, 8'h23, 8'h1B, 8'h1C}),
    .KEY_EXT(8'h80),
    .TIMEOUT_CYCLES(16)
  ) u_b (
    .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_b), .rx_valid(vld_b), .clear_all(clr_b),
    .key_state(ks_b), .no_press(np_b), .active_count(cnt_b),
    .event_valid(ev_b), .event_key(key_b), .event_make(mk_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string p, input exp_t e, input logic [7:0] ks, input logic np,
                     input logic [3:0] cnt, input logic ev, input logic [2:0] key, input logic mk);
    chk({p, "_key_state"}, 32'(ks), 32'(e.ks));
    chk({p, "_no_press"}, 32'(np), 32'(e.ks == 8'h00));
    chk({p, "_active_count"}, 32'(cnt), 32'($countones(e.ks)));
    chk({p, "_event_valid"}, 32'(ev), 32'(e.ev));
    if (e.ev) begin
      chk({p, "_event_key"}, 32'(key), 32'(e.key));
      chk({p, "_event_make"}, 32'(mk), 32'(e.mk));
    end
  endtask

  initial begin : mon_a
    forever begin
      @(posedge clk);
      #1;
      if (resetn && qa.size() > 0) begin
        exp_t e;
        e = qa.pop_front();
        cmp("a", e, ks_a, np_a, cnt_a, ev_a, key_a, mk_a);
      end else if (ev_a) begin
        chk("a_unexpected_event", 32'(ev_a), 32'd0);
      end
    end
  end

  initial begin : mon_b
    forever begin
      @(posedge clk);
      #1;
      if (resetn && qb.size() > 0) begin
        exp_t e;
        e = qb.pop_front();
        cmp("b", e, ks_b, np_b, cnt_b, ev_b, key_b, mk_b);
      end else if (ev_b) begin
        chk("b_unexpected_event", 32'(ev_b), 32'd0);
      end
    end
  end

  task automatic send(input bit sel_b, input logic [7:0] d, input bit clr,
                      input logic [7:0] ks, input bit ev, input logic [2:0] key, input bit mk);
    exp_t e;
    e = '{ks: ks, ev: ev, key: key, mk: mk};
    @(negedge clk);
    vld_a = 1'b0; clr_a = 1'b0; vld_b = 1'b0; clr_b = 1'b0;
    if (!sel_b) begin
      rx_a = d; vld_a = 1'b1; clr_a = clr; qa.push_back(e);
    end else begin
      rx_b = d; vld_b = 1'b1; clr_b = clr; qb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld_a = 1'b0; clr_a = 1'b0; vld_b = 1'b0; clr_b = 1'b0;
    end
  endtask

  task automatic chk_reset();
    chk("a_rst_key_state", 32'(ks_a), 32'd0);
    chk("a_rst_no_press", 32'(np_a), 32'd1);
    chk("a_rst_active_count", 32'(cnt_a), 32'd0);
    chk("a_rst_event_valid", 32'(ev_a), 32'd0);
    chk("a_rst_event_key", 32'(key_a), 32'd0);
    chk("a_rst_event_make", 32'(mk_a), 32'd0);
    chk("b_rst_key_state", 32'(ks_b), 32'd0);
    chk("b_rst_no_press", 32'(np_b), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    idle(2);

    // instance A: default map, A=1C(0) S=1B(1) D=23(2) F=2B(3)
    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    send(0, 8'h23, 0, 8'h05, 1, 3'd2, 1);
    send(0, 8'hF0, 0, 8'h05, 0, 3'd0, 0);
    send(0, 8'h1C, 0, 8'h04, 1, 3'd0, 0);
    send(0, 8'hF0, 0, 8'h04, 0, 3'd0, 0);
    send(0, 8'h1C, 0, 8'h04, 0, 3'd0, 0);
    send(0, 8'h77, 0, 8'h04, 0, 3'd0, 0);
    send(0, 8'hE0, 0, 8'h04, 0, 3'd0, 0);
    send(0, 8'h23, 0, 8'h04, 0, 3'd0, 0);
    send(0, 8'hF0, 0, 8'h04, 0, 3'd0, 0);
    send(0, 8'h23, 0, 8'h00, 1, 3'd2, 0);
    idle(2);

    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    send(0, 8'h1C, 0, 8'h01, 0, 3'd0, 0);
    send(0, 8'h1C, 0, 8'h01, 0, 3'd0, 0);
`else
    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
`endif
    send(0, 8'h2B, 0, 8'h09, 1, 3'd3, 1);
    send(0, 8'h1B, 1, 8'h00, 0, 3'd0, 0);
    idle(2);

    // clear_all also drops a pending F0 prefix
    send(0, 8'hF0, 0, 8'h00, 0, 3'd0, 0);
    send(0, 8'h00, 1, 8'h00, 0, 3'd0, 0);
    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    send(0, 8'hF0, 0, 8'h01, 0, 3'd0, 0);
    send(0, 8'h1C, 0, 8'h00, 1, 3'd0, 0);

    // default prefix timeout: exactly 50000 idle cycles after F0
    send(0, 8'hF0, 0, 8'h00, 0, 3'd0, 0);
    idle(50000);
    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    idle(2);

    // instance B: key 7 = E0 74, timeout 16 cycles
    send(1, 8'h74, 0, 8'h00, 0, 3'd0, 0);
    send(1, 8'hE0, 0, 8'h00, 0, 3'd0, 0);
    send(1, 8'h74, 0, 8'h80, 1, 3'd7, 1);
    send(1, 8'hF0, 0, 8'h80, 0, 3'd0, 0);
    send(1, 8'h74, 0, 8'h80, 0, 3'd0, 0);
    send(1, 8'hE0, 0, 8'h80, 0, 3'd0, 0);
    send(1, 8'hF0, 0, 8'h80, 0, 3'd0, 0);
    send(1, 8'h74, 0, 8'h00, 1, 3'd7, 0);
    send(1, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    send(1, 8'hF0, 0, 8'h01, 0, 3'd0, 0);
    idle(12);
    send(1, 8'h1C, 0, 8'h00, 1, 3'd0, 0);
    send(1, 8'hF0, 0, 8'h00, 0, 3'd0, 0);
    idle(20);
    send(1, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    send(1, 8'hE0, 0, 8'h01, 0, 3'd0, 0);
    idle(20);
    send(1, 8'h74, 0, 8'h01, 0, 3'd0, 0);
    idle(2);

    // reset in the middle of a break sequence
    send(0, 8'hF0, 0, 8'h01, 0, 3'd0, 0);
    @(negedge clk);
    vld_a = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    send(0, 8'h1C, 0, 8'h01, 1, 3'd0, 1);
    idle(3);

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
